// File: rtl/random_sampler_pkg.sv
// Shared FSM encoding and constants for random_sampler and the Dyna-Q index samplers.
package random_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_SEED_INIT = 32'h1ACE_B00C;
  // The PRNG locks up when every state bit is set.
  localparam logic        LOCKUP_FILL       = 1'b1;
  localparam int          STATS_W           = 16;

endpackage

// File: rtl/random_sampler_if.sv
// Request/response handshake between a sampler client (master) and random_sampler (slave).
interface random_sampler_if #(
  parameter int RANGE_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [RANGE_WIDTH-1:0] req_range;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [RANGE_WIDTH-1:0] rsp_value;
  logic                   rsp_fallback;

  modport master (
    output req_valid, req_range, rsp_ready,
    input  req_ready, rsp_valid, rsp_value, rsp_fallback
  );

  modport slave (
    input  req_valid, req_range, rsp_ready,
    output req_ready, rsp_valid, rsp_value, rsp_fallback
  );
endinterface

// File: rtl/range_mask.sv
// Combinational range-to-mask: smallest 2^k-1 covering N-1 (bit-smear of N-1).
module range_mask #(
  parameter int RANGE_WIDTH = 8
) (
  input  logic [RANGE_WIDTH-1:0] i_range,
  output logic [RANGE_WIDTH-1:0] o_mask
);
  logic [RANGE_WIDTH-1:0] w_limit;

  assign w_limit = i_range - RANGE_WIDTH'(1);

  // Bit gi is set when any bit at or above gi of N-1 is set.
  for (genvar gi = 0; gi < RANGE_WIDTH; gi++) begin : g_smear
    assign o_mask[gi] = |w_limit[RANGE_WIDTH-1:gi];
  end
endmodule

// File: rtl/random_sampler.sv
// Bounded-random source: free-running PRNG plus rejection sampler over a valid/ready handshake.
// Optional SAMPLER_STATS_EN adds saturating response/fallback counters.
module random_sampler
  import random_sampler_pkg::*;
#(
  parameter int                     DATA_LENGTH  = 32,
  parameter int                     RANGE_WIDTH  = 8,
  parameter int                     MAX_TRIES    = 16,
  parameter logic [DATA_LENGTH-1:0] DEFAULT_SEED = DATA_LENGTH'(DEFAULT_SEED_INIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_load,
  input  logic [DATA_LENGTH-1:0] seed_in,
  output logic [DATA_LENGTH-1:0] state_out,
`ifdef SAMPLER_STATS_EN
  output logic [STATS_W-1:0]     rsp_count,
  output logic [STATS_W-1:0]     fallback_count,
`endif
  random_sampler_if.slave        bus
);
  localparam int                     TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0]     LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [DATA_LENGTH-1:0] LOCKUP   = {DATA_LENGTH{LOCKUP_FILL}};
  localparam int                     HALF     = DATA_LENGTH / 2;

  logic [DATA_LENGTH-1:0] r_prng;
  state_t                 r_state, w_state_next;
  logic [RANGE_WIDTH-1:0] r_range, w_range_next;
  logic [RANGE_WIDTH-1:0] r_mask, w_mask_next;
  logic [RANGE_WIDTH-1:0] r_value, w_value_next;
  logic                   r_fallback, w_fallback_next;
  logic [TRIES_W-1:0]     r_tries, w_tries_next;
  logic [RANGE_WIDTH-1:0] w_mask;
  logic [RANGE_WIDTH-1:0] w_cand;

  range_mask #(.RANGE_WIDTH(RANGE_WIDTH)) u_range_mask (
    .i_range (bus.req_range),
    .o_mask  (w_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prng <= DEFAULT_SEED;
    end else if (seed_load) begin
      r_prng <= (seed_in == LOCKUP) ? DEFAULT_SEED : seed_in;
    end else begin
      r_prng <= {r_prng[DATA_LENGTH-2:0], ~^r_prng[DATA_LENGTH-1:HALF]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_range    <= '0;
      r_mask     <= '0;
      r_value    <= '0;
      r_fallback <= 1'b0;
      r_tries    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_range    <= w_range_next;
      r_mask     <= w_mask_next;
      r_value    <= w_value_next;
      r_fallback <= w_fallback_next;
      r_tries    <= w_tries_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_range_next    = r_range;
    w_mask_next     = r_mask;
    w_value_next    = r_value;
    w_fallback_next = r_fallback;
    w_tries_next    = r_tries;
    w_cand          = r_prng[RANGE_WIDTH-1:0] & r_mask;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_range_next = bus.req_range;
          w_mask_next  = w_mask;
          if (bus.req_range <= RANGE_WIDTH'(1)) begin
            w_value_next    = '0;
            w_fallback_next = 1'b0;
            w_state_next    = ST_RESP;
          end else begin
            w_state_next = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        if (w_cand < r_range) begin
          w_value_next    = w_cand;
          w_fallback_next = 1'b0;
          w_state_next    = ST_RESP;
        end else if (r_tries == LAST_TRY) begin
          // mask < 2N, so a rejected candidate folds into [0, N) with one subtraction.
          w_value_next    = w_cand - r_range;
          w_fallback_next = 1'b1;
          w_state_next    = ST_RESP;
        end else begin
          w_tries_next = r_tries + TRIES_W'(1);
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_tries_next = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.rsp_value    = r_value;
  assign bus.rsp_fallback = r_fallback;
  assign state_out        = r_prng;

`ifdef SAMPLER_STATS_EN
  logic               w_handshake;
  logic [STATS_W-1:0] r_rsp_count;
  logic [STATS_W-1:0] r_fallback_count;

  assign w_handshake = (r_state == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_count      <= '0;
      r_fallback_count <= '0;
    end else if (w_handshake) begin
      if (r_rsp_count != '1) r_rsp_count <= r_rsp_count + STATS_W'(1);
      if (r_fallback && (r_fallback_count != '1)) r_fallback_count <= r_fallback_count + STATS_W'(1);
    end
  end

  assign rsp_count      = r_rsp_count;
  assign fallback_count = r_fallback_count;
`endif
endmodule

// File: tb/tb_random_sampler.sv
// Directed bench for random_sampler: instance 0 uses MAX_TRIES=16, instance 1 uses MAX_TRIES=1.
module tb_random_sampler;
  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed_in;
  logic [31:0] state_a, state_b;
  logic [31:0] m_state;

  logic        v_req_valid [2];
  logic [7:0]  v_req_range [2];
  logic        v_rsp_ready [2];
  logic        o_req_ready [2];
  logic        o_rsp_valid [2];
  logic [7:0]  o_rsp_value [2];
  logic        o_rsp_fb    [2];
  logic [31:0] o_state     [2];
  int          e_rsp [2];
  int          e_fb  [2];

  int n_checks;
  int n_fail;

  random_sampler_if #(.RANGE_WIDTH(8)) if_a ();
  random_sampler_if #(.RANGE_WIDTH(8)) if_b ();

`ifdef SAMPLER_STATS_EN
  logic [15:0] rc_a, fc_a, rc_b, fc_b;
`endif

  random_sampler #(.MAX_TRIES(16)) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .seed_load      (seed_load),
    .seed_in        (seed_in),
    .state_out      (state_a),
`ifdef SAMPLER_STATS_EN
    .rsp_count      (rc_a),
    .fallback_count (fc_a),
`endif
    .bus            (if_a)
  );

  random_sampler #(.MAX_TRIES(1)) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .seed_load      (seed_load),
    .seed_in        (seed_in),
    .state_out      (state_b),
`ifdef SAMPLER_STATS_EN
    .rsp_count      (rc_b),
    .fallback_count (fc_b),
`endif
    .bus            (if_b)
  );

  assign if_a.req_valid = v_req_valid[0];
  assign if_a.req_range = v_req_range[0];
  assign if_a.rsp_ready = v_rsp_ready[0];
  assign if_b.req_valid = v_req_valid[1];
  assign if_b.req_range = v_req_range[1];
  assign if_b.rsp_ready = v_rsp_ready[1];
  assign o_req_ready[0] = if_a.req_ready;
  assign o_rsp_valid[0] = if_a.rsp_valid;
  assign o_rsp_value[0] = if_a.rsp_value;
  assign o_rsp_fb[0]    = if_a.rsp_fallback;
  assign o_state[0]     = state_a;
  assign o_req_ready[1] = if_b.req_ready;
  assign o_rsp_valid[1] = if_b.rsp_valid;
  assign o_rsp_value[1] = if_b.rsp_value;
  assign o_rsp_fb[1]    = if_b.rsp_fallback;
  assign o_state[1]     = state_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], ~^s[31:16]};
  endfunction

  // Reference PRNG state, shared by both instances.
  always @(posedge clk) begin
    if (rst) m_state <= 32'h1ACE_B00C;
    else if (seed_load) m_state <= (seed_in == 32'hFFFF_FFFF) ? 32'h1ACE_B00C : seed_in;
    else m_state <= step(m_state);
  end

  task automatic do_req(input int w, input logic [7:0] n, input logic [7:0] mask,
                        input int maxt, input int hold);
    logic [31:0] s;
    logic [7:0]  cand;
    logic [7:0]  exp_v;
    logic        exp_fb;
    int          exp_lat;
    int          tries;
    int          lat;
    @(negedge clk);
    n_checks++;
    if (o_req_ready[w] !== 1'b1 || o_state[w] !== m_state) begin
      n_fail++;
      $display("FAIL idle_before_req w=%0d req_ready=%b state=%h required ready=1 state=%h",
               w, o_req_ready[w], o_state[w], m_state);
    end
    v_req_valid[w] = 1'b1;
    v_req_range[w] = n;
    @(posedge clk);
    #1;
    v_req_valid[w] = 1'b0;
    exp_v   = 8'd0;
    exp_fb  = 1'b0;
    exp_lat = 0;
    if (n <= 8'd1) begin
      exp_lat = 1;
    end else begin
      s     = m_state;
      tries = 0;
      while (exp_lat == 0) begin
        cand = s[7:0] & mask;
        if (cand < n) begin
          exp_v   = cand;
          exp_lat = tries + 2;
        end else if (tries == maxt - 1) begin
          exp_v   = cand - n;
          exp_fb  = 1'b1;
          exp_lat = tries + 2;
        end else begin
          tries++;
          s = step(s);
        end
      end
    end
    lat = 1;
    while (o_rsp_valid[w] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== exp_lat || o_rsp_value[w] !== exp_v || o_rsp_fb[w] !== exp_fb) begin
      n_fail++;
      $display("FAIL response w=%0d n=%0d got lat=%0d value=%0d fb=%b required lat=%0d value=%0d fb=%b",
               w, n, lat, o_rsp_value[w], o_rsp_fb[w], exp_lat, exp_v, exp_fb);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (o_rsp_valid[w] !== 1'b1 || o_req_ready[w] !== 1'b0 ||
          o_rsp_value[w] !== exp_v || o_rsp_fb[w] !== exp_fb) begin
        n_fail++;
        $display("FAIL backpressure_hold w=%0d cyc=%0d got valid=%b ready=%b value=%0d fb=%b required 1 0 %0d %b",
                 w, h, o_rsp_valid[w], o_req_ready[w], o_rsp_value[w], o_rsp_fb[w], exp_v, exp_fb);
      end
    end
    v_rsp_ready[w] = 1'b1;
    @(posedge clk);
    #1;
    v_rsp_ready[w] = 1'b0;
    n_checks++;
    if (o_rsp_valid[w] !== 1'b0 || o_req_ready[w] !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake w=%0d got valid=%b ready=%b required valid=0 ready=1",
               w, o_rsp_valid[w], o_req_ready[w]);
    end
    e_rsp[w]++;
    if (exp_fb) e_fb[w]++;
    $display("txn w=%0d n=%0d value=%0d fb=%0d lat=%0d", w, n, exp_v, exp_fb, exp_lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (state_a !== 32'h1ACE_B00C || state_b !== 32'h1ACE_B00C) begin
      n_fail++;
      $display("FAIL reset_state got a=%h b=%h required 1aceb00c", state_a, state_b);
    end
    n_checks++;
    if (o_rsp_valid[0] !== 1'b0 || o_req_ready[0] !== 1'b1 ||
        o_rsp_valid[1] !== 1'b0 || o_req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake got valid=%b/%b ready=%b/%b required valid=0 ready=1",
               o_rsp_valid[0], o_rsp_valid[1], o_req_ready[0], o_req_ready[1]);
    end
    n_checks++;
    if (o_rsp_value[0] !== 8'd0 || o_rsp_fb[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp got value=%0d fb=%b required 0 0", o_rsp_value[0], o_rsp_fb[0]);
    end
    rst = 1'b0;
    e_rsp[0] = 0; e_rsp[1] = 0; e_fb[0] = 0; e_fb[1] = 0;
    @(negedge clk);
    n_checks++;
    if (state_a !== 32'h359D_6019) begin
      n_fail++;
      $display("FAIL first_step got=%h required=359d6019", state_a);
    end
  endtask

  task automatic test_seed();
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 32'hFFFF_FFFF;
    @(negedge clk);
    seed_load = 1'b0;
    n_checks++;
    if (state_a !== 32'h1ACE_B00C) begin
      n_fail++;
      $display("FAIL lockup_seed got=%h required=1aceb00c", state_a);
    end
    seed_load = 1'b1;
    seed_in   = 32'h0000_0001;
    @(negedge clk);
    seed_load = 1'b0;
    n_checks++;
    if (state_a !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL seed_one got=%h required=00000001", state_a);
    end
    @(negedge clk);
    n_checks++;
    if (state_a !== 32'h0000_0003 || state_b !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL seed_step1 got a=%h b=%h required=00000003", state_a, state_b);
    end
    @(negedge clk);
    n_checks++;
    if (state_a !== 32'h0000_0007) begin
      n_fail++;
      $display("FAIL seed_step2 got=%h required=00000007", state_a);
    end
  endtask

  task automatic test_small_range();
    do_req(0, 8'd0, 8'hFF, 16, 0);
    do_req(0, 8'd1, 8'h00, 16, 0);
    do_req(1, 8'd0, 8'hFF, 1, 0);
    do_req(1, 8'd1, 8'h00, 1, 0);
  endtask

  task automatic test_range8();
    for (int i = 0; i < 20; i++) do_req(0, 8'd8, 8'h07, 16, 0);
  endtask

  task automatic test_back_to_back();
    do_req(0, 8'd8, 8'h07, 16, 5);
    do_req(0, 8'd0, 8'hFF, 16, 5);
    do_req(1, 8'd5, 8'h07, 1, 5);
  endtask

  task automatic test_retry();
    logic [7:0] ranges [6];
    logic [7:0] masks  [6];
    ranges = '{8'd5, 8'd3, 8'd100, 8'd200, 8'd255, 8'd2};
    masks  = '{8'h07, 8'h03, 8'h7F, 8'hFF, 8'hFF, 8'h01};
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 30; i++) do_req(0, ranges[r], masks[r], 16, 0);
    end
  endtask

  task automatic test_fallback();
    for (int i = 0; i < 1000; i++) begin
      if (i % 10 == 0) begin
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = $urandom;
        @(negedge clk);
        seed_load = 1'b0;
      end
      do_req(1, 8'd5, 8'h07, 1, 0);
    end
`ifdef SAMPLER_STATS_EN
    @(negedge clk);
    n_checks++;
    if (rc_b !== 16'(e_rsp[1]) || fc_b !== 16'(e_fb[1]) ||
        rc_a !== 16'(e_rsp[0]) || fc_a !== 16'(e_fb[0])) begin
      n_fail++;
      $display("FAIL stats got a=%0d/%0d b=%0d/%0d required a=%0d/%0d b=%0d/%0d",
               rc_a, fc_a, rc_b, fc_b, e_rsp[0], e_fb[0], e_rsp[1], e_fb[1]);
    end
`endif
  endtask

  task automatic test_rst_mid();
    // Reset while instance 0 is drawing.
    @(negedge clk);
    v_req_valid[0] = 1'b1;
    v_req_range[0] = 8'd200;
    @(posedge clk);
    #1;
    v_req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (o_rsp_valid[0] !== 1'b0 || o_req_ready[0] !== 1'b1 || state_a !== 32'h1ACE_B00C) begin
      n_fail++;
      $display("FAIL rst_in_draw got valid=%b ready=%b state=%h required 0 1 1aceb00c",
               o_rsp_valid[0], o_req_ready[0], state_a);
    end
    // Reset while instance 0 holds a response.
    @(negedge clk);
    v_req_valid[0] = 1'b1;
    v_req_range[0] = 8'd0;
    @(posedge clk);
    #1;
    v_req_valid[0] = 1'b0;
    n_checks++;
    if (o_rsp_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_before_rst got valid=%b required 1", o_rsp_valid[0]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e_rsp[0] = 0; e_rsp[1] = 0; e_fb[0] = 0; e_fb[1] = 0;
    n_checks++;
    if (o_rsp_valid[0] !== 1'b0 || o_req_ready[0] !== 1'b1 || state_a !== 32'h1ACE_B00C) begin
      n_fail++;
      $display("FAIL rst_in_resp got valid=%b ready=%b state=%h required 0 1 1aceb00c",
               o_rsp_valid[0], o_req_ready[0], state_a);
    end
`ifdef SAMPLER_STATS_EN
    n_checks++;
    if (rc_a !== 16'd0 || fc_b !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear got rc_a=%0d fc_b=%0d required 0 0", rc_a, fc_b);
    end
`endif
    do_req(0, 8'd5, 8'h07, 16, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = 32'd0;
    for (int k = 0; k < 2; k++) begin
      v_req_valid[k] = 1'b0;
      v_req_range[k] = 8'd0;
      v_rsp_ready[k] = 1'b0;
      e_rsp[k]       = 0;
      e_fb[k]        = 0;
    end
    test_reset();
    test_seed();
    test_small_range();
    test_range8();
    test_back_to_back();
    test_retry();
    test_fallback();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
